phase_bank: RTL

PHASE_BANK -- requirements
Module: phase_bank

---
 rtl/phase_bank_if.sv | 24 ++
 rtl/phase_bank.sv | 80 ++++++++
 2 files changed

// File: rtl/phase_bank_if.sv
// rtl/phase_bank_if.sv - command/strobe inputs and phase/status outputs of phase_bank
// master drives the command side; slave is the phase_bank instance.
interface phase_bank_if #(
  parameter int NUM_CH  = 64,
  parameter int PHASE_W = 8
);
  logic [31:0]               latest_data;
  logic                      phase_parse_en;
  logic                      phase_calib_en;
  logic [NUM_CH*PHASE_W-1:0] phases_out;
  logic                      commit_pulse;
  logic [15:0]               commit_count;
  logic                      addr_error;

  modport master (
    output latest_data, phase_parse_en, phase_calib_en,
    input  phases_out, commit_pulse, commit_count, addr_error
  );

  modport slave (
    input  latest_data, phase_parse_en, phase_calib_en,
    output phases_out, commit_pulse, commit_count, addr_error
  );
endinterface

// File: rtl/phase_bank.sv
// rtl/phase_bank.sv - double-buffered transducer phase bank with commit and optional calibration
// Define PHASE_BANK_CALIB_EN to add per-channel offsets applied at commit time.
module phase_bank #(
  parameter int NUM_CH  = 64,
  parameter int PHASE_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  phase_bank_if.slave  bus
);

  logic [7:0]         w_addr;
  logic [PHASE_W-1:0] w_phase;
  logic               w_addr_ok;
  logic               w_commit;
  logic               w_addr_bad;
  logic               w_unused;

  logic [PHASE_W-1:0]        r_shadow [NUM_CH];
  logic [NUM_CH*PHASE_W-1:0] r_phases;
  logic                      r_pulse;
  logic [15:0]               r_count;
  logic                      r_err;

  assign w_addr    = bus.latest_data[7:0];
  assign w_phase   = bus.latest_data[8 +: PHASE_W];
  assign w_addr_ok = ({1'b0, w_addr} < 9'(NUM_CH));
  assign w_commit  = bus.phase_parse_en && (w_addr == 8'hFF);
  // 8'hFF is the commit code on the phase strobe and a silent no-op on the calib strobe
  assign w_addr_bad = (bus.phase_parse_en || bus.phase_calib_en) && !w_addr_ok && (w_addr != 8'hFF);
  assign w_unused  = ^bus.latest_data;

`ifdef PHASE_BANK_CALIB_EN
  logic [PHASE_W-1:0] r_calib [NUM_CH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
`ifdef PHASE_BANK_CALIB_EN
        r_calib[i]  <= '0;
`endif
      end
      r_phases <= '0;
      r_pulse  <= 1'b0;
      r_count  <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_pulse <= w_commit;
      if (w_commit) begin
        r_count <= r_count + 16'd1;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef PHASE_BANK_CALIB_EN
          r_phases[i*PHASE_W +: PHASE_W] <= r_shadow[i] + r_calib[i];
`else
          r_phases[i*PHASE_W +: PHASE_W] <= r_shadow[i];
`endif
        end
      end
      // Writes land in the same edge as a commit; the commit still sees the old values
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.phase_parse_en && w_addr_ok && (w_addr == 8'(i)))
          r_shadow[i] <= w_phase;
`ifdef PHASE_BANK_CALIB_EN
        if (bus.phase_calib_en && w_addr_ok && (w_addr == 8'(i)))
          r_calib[i] <= w_phase;
`endif
      end
      if (w_addr_bad)
        r_err <= 1'b1;
    end
  end

  assign bus.phases_out   = r_phases;
  assign bus.commit_pulse = r_pulse;
  assign bus.commit_count = r_count;
  assign bus.addr_error   = r_err;

endmodule
